// File: rtl/params_pkg.sv
// Shared types and constants for the instruction-fetch stage and the IF/ID boundary.
package params_pkg;

  // Canonical NOP (addi x0, x0, 0) shown whenever no real instruction is held.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_WAIT  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic [31:0] insn;
  } if_id_t;

  // Redirect targets may arrive misaligned; fetch addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one instruction-memory request at a
// time, buffers the returned instruction for the IF/ID register and handles redirects
// from EX, including dropping a response that was already in flight.
module fetch_stage
  import params_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output if_id_t      if_id_o,
  output logic        if_stall_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         discard_q, discard_d;
  if_id_t       buf_q, buf_d;

  logic         consume;
  logic [31:0]  redirect_target;

  // The IF/ID register takes the buffered word on any cycle it is not stalled.
  assign consume         = buf_q.valid && !stall_i;
  assign redirect_target = word_align(redirect_pc_i);

  // State and buffer registers; reset puts a NOP-shaped, invalid word on the output.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      req_pc_q  <= '0;
      discard_q <= 1'b0;
      buf_q     <= '{valid: 1'b0, pc: 32'h0, pc_plus_4: 32'h0, insn: NOP_INSN};
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      discard_q <= discard_d;
      buf_q     <= buf_d;
    end
  end

  // Next-state: handshake progress, response capture, then redirect overriding both.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    discard_d = discard_q;
    buf_d     = buf_q;

    if (consume) begin
      buf_d.valid = 1'b0;
    end

    unique case (state_q)
      ST_FETCH: begin
        // A response arriving here has no owner and is ignored.
        if (imem_req_o && imem_gnt_i) begin
          state_d  = ST_WAIT;
          req_pc_d = pc_q;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          state_d = ST_FETCH;
          if (discard_q) begin
            // Stale response for a pre-redirect PC; pc already holds the new target.
            discard_d = 1'b0;
          end else begin
            // A write here wins over a same-cycle consume.
            buf_d = '{valid:     1'b1,
                      pc:        req_pc_q,
                      pc_plus_4: req_pc_q + 32'd4,
                      insn:      imem_rdata_i};
            pc_d  = req_pc_q + 32'd4;
          end
        end
      end
      default: ;
    endcase

    if (redirect_i) begin
      pc_d        = redirect_target;
      buf_d       = buf_q;
      buf_d.valid = 1'b0;
      if (state_q == ST_WAIT) begin
        if (imem_rvalid_i) begin
          // The in-flight response lands now, so nothing is left to discard later.
          state_d   = ST_FETCH;
          discard_d = 1'b0;
        end else begin
          discard_d = 1'b1;
        end
      end
    end
  end

  // Outputs: request only from FETCH with room in the buffer, never during a redirect.
  always_comb begin
    imem_req_o  = (state_q == ST_FETCH) && !rst_i && !redirect_i && (!buf_q.valid || consume);
    imem_addr_o = pc_q;
    if_id_o     = buf_q;
    if_stall_o  = !buf_q.valid;
  end

`ifdef FORMAL
  a_one_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == ST_WAIT) |-> !imem_req_o);

  a_addr_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (imem_req_o && !imem_gnt_i) |=> $stable(imem_addr_o));

  a_out_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (stall_i && !redirect_i && if_id_o.valid) |=> $stable(if_id_o));

  a_rvalid_legal: assert property (@(posedge clk_i) disable iff (rst_i)
    imem_rvalid_i |-> (state_q == ST_WAIT));
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a small instruction-memory model with programmable
// grant delay, a scoreboard of expected IF/ID words and a monitor that checks every
// word the IF/ID register takes.
module tb_fetch_stage;
  import params_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  if_id_t      if_id_o;
  logic        if_stall_o;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .if_id_o      (if_id_o),
    .if_stall_o   (if_stall_o)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard and counters
  if_id_t exp_q[$];
  int     checks = 0;
  int     failures = 0;
  int     mon_checks = 0;
  int     mon_fails = 0;

  // Memory model state
  int          gnt_delay = 0;
  int          gnt_wait = 0;
  bit          hold_resp = 1'b0;
  bit          resp_pending = 1'b0;
  bit          grant_now = 1'b0;
  logic [31:0] resp_addr = '0;
  logic [31:0] grant_addr = '0;
  int          hs_count = 0;
  int          hs_base = 0;

  localparam logic [96:0] RESET_WORD = {1'b0, 32'h0, 32'h0, 32'h0000_0013};

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC000_0000 | a;
  endfunction

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] pc4, input logic [31:0] insn);
    if_id_t e;
    e.valid     = 1'b1;
    e.pc        = pc;
    e.pc_plus_4 = pc4;
    e.insn      = insn;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock cycle: memory answers for the current cycle, then the edge.
  task automatic step();
    #1;
    grant_now = 1'b0;
    if (resp_pending && !hold_resp) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(resp_addr);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'h0BAD_0BAD;
    end
    if (imem_req_o) begin
      if (gnt_wait >= gnt_delay) begin
        imem_gnt_i = 1'b1;
        grant_now  = 1'b1;
        grant_addr = imem_addr_o;
      end else begin
        imem_gnt_i = 1'b0;
        gnt_wait++;
      end
    end else begin
      imem_gnt_i = 1'b0;
    end
    @(posedge clk_i);
    if (imem_rvalid_i) resp_pending = 1'b0;
    if (grant_now) begin
      resp_pending = 1'b1;
      resp_addr    = grant_addr;
      gnt_wait     = 0;
      hs_count++;
    end
    #1;
  endtask

  // Monitor: every word taken by the IF/ID register must match the scoreboard head.
  always @(negedge clk_i) begin
    if_id_t e;
    if (!rst_i && if_id_o.valid && !stall_i && !redirect_i) begin
      mon_checks++;
      if (exp_q.size() == 0) begin
        mon_fails++;
        $display("FAIL sb_unexpected: actual pc=%h insn=%h required no word", if_id_o.pc, if_id_o.insn);
      end else begin
        e = exp_q.pop_front();
        if (if_id_o !== e) begin
          mon_fails++;
          $display("FAIL sb_word: actual {%b,%h,%h,%h} required {%b,%h,%h,%h}",
                   if_id_o.valid, if_id_o.pc, if_id_o.pc_plus_4, if_id_o.insn,
                   e.valid, e.pc, e.pc_plus_4, e.insn);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    repeat (3) step();

    // Reset values
    chk("rst_req", imem_req_o, 0);
    chk("rst_stall", if_stall_o, 1);
    chk("rst_ifid", if_id_o, RESET_WORD);

    // Test 1: zero-wait memory
    push_exp(32'h0, 32'h4, 32'hC000_0000);
    rst_i = 1'b0;
    #1;
    chk("t1_first_req", imem_req_o, 1);
    chk("t1_first_addr", imem_addr_o, 32'h0);
    step();
    chk("t1_stall_wait", if_stall_o, 1);
    step();
    chk("t1_stall_full", if_stall_o, 0);
    chk("t1_next_addr", imem_addr_o, 32'h4);

    // Test 2: grant for 0x4 delayed 3 cycles
    gnt_delay = 3;
    hs_base = hs_count;
    push_exp(32'h4, 32'h8, 32'hC000_0004);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("t2_req_hold", imem_req_o, 1);
      chk("t2_addr_hold", imem_addr_o, 32'h4);
      step();
    end
    gnt_delay = 0;
    chk("t2_one_handshake", hs_count - hs_base, 1);
    chk("t2_wait_no_req", imem_req_o, 0);
    push_exp(32'h8, 32'hC, 32'hC000_0008);
    step();
    step();
    step();
    chk("t2_handshakes", hs_count - hs_base, 2);

    // Test 3: stall with a full buffer
    stall_i = 1'b1;
    #1;
    hs_base = hs_count;
    for (int i = 0; i < 5; i++) begin
      chk("t3_no_req", imem_req_o, 0);
      chk("t3_hold_word", if_id_o, {1'b1, 32'h8, 32'hC, 32'hC000_0008});
      step();
    end
    chk("t3_no_handshake", hs_count - hs_base, 0);
    stall_i = 1'b0;
    #1;
    chk("t3_release_req", imem_req_o, 1);
    chk("t3_release_addr", imem_addr_o, 32'hC);

    // Test 4: redirect to 0x100 while 0x10 is in flight
    push_exp(32'hC, 32'h10, 32'hC000_000C);
    step();
    step();
    hold_resp = 1'b1;
    step();
    chk("t4_in_flight_addr", resp_addr, 32'h10);
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0100;
    #1;
    chk("t4_redirect_no_req", imem_req_o, 0);
    step();
    redirect_i = 1'b0;
    #1;
    chk("t4_wait_no_req", imem_req_o, 0);
    step();
    hold_resp = 1'b0;
    step();
    chk("t4_after_drop_stall", if_stall_o, 1);
    chk("t4_refetch_addr", imem_addr_o, 32'h100);
    chk("t4_refetch_req", imem_req_o, 1);
    push_exp(32'h100, 32'h104, 32'hC000_0100);
    step();
    step();
    chk("t4_word_pc", if_id_o.pc, 32'h100);

    // Test 5: redirect to 0x203 coincident with the 0x104 response
    step();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0203;
    step();
    redirect_i = 1'b0;
    #1;
    chk("t5_stall", if_stall_o, 1);
    chk("t5_req", imem_req_o, 1);
    chk("t5_addr", imem_addr_o, 32'h200);
    push_exp(32'h200, 32'h204, 32'hC000_0200);
    step();
    step();
    chk("t5_word_pc", if_id_o.pc, 32'h200);

    // Test 6: reset while 0x204 is in flight, stray response afterwards
    step();
    hold_resp = 1'b1;
    rst_i = 1'b1;
    step();
    step();
    chk("t6_rst_req", imem_req_o, 0);
    chk("t6_rst_stall", if_stall_o, 1);
    chk("t6_rst_ifid", if_id_o, RESET_WORD);
    rst_i = 1'b0;
    hold_resp = 1'b0;
    #1;
    chk("t6_first_req", imem_req_o, 1);
    chk("t6_first_addr", imem_addr_o, 32'h0);
    push_exp(32'h0, 32'h4, 32'hC000_0000);
    step();
    chk("t6_wait_stall", if_stall_o, 1);
    step();
    chk("t6_word", if_id_o, {1'b1, 32'h0, 32'h4, 32'hC000_0000});
    step();
    stall_i = 1'b1;
    step();
    step();
    step();
    chk("t6_stalled_word", if_id_o, {1'b1, 32'h4, 32'h8, 32'hC000_0004});
    chk("t6_stalled_no_req", imem_req_o, 0);

    chk("sb_drained", exp_q.size(), 0);
    chk("sb_words_taken", mon_checks, 7);
    checks   = checks + mon_checks;
    failures = failures + mon_fails;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
